// File: rtl/aurora_tx_link_gate.sv
// Gates whole CHDR packets onto the Aurora TX user port: forwards only while the link is up, discards or truncates cleanly on link loss.
// Latency 1 cycle (2-entry skid buffer). Optional counters via AURORA_TX_LINK_GATE_STATS_EN.
module aurora_tx_link_gate #(
  parameter int AXIS_AURORA_W = 256,
  parameter int CNT_W         = 32
) (
  input  logic                     aurora_clk,
  input  logic                     aurora_rst,
  input  logic                     channel_up,
  input  logic                     tx_pause,
  input  logic [AXIS_AURORA_W-1:0] s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [AXIS_AURORA_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  input  logic                     clear_stats,
  output logic [CNT_W-1:0]         pkt_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         trunc_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_drop_trunc, w_drop_trunc_nxt;
  logic [AXIS_AURORA_W-1:0] r_dat0, r_dat1;
  logic                     r_last0, r_last1;
  logic [1:0]               r_cnt;
  logic [1:0]               w_rem;
  logic                     w_full, w_out_fire, w_fwd, w_flush, w_tready;
  logic                     w_drop_inc, w_pkt_inc;

  assign w_full        = (r_cnt == 2'd2);
  assign m_axis_tvalid = (r_cnt != 2'd0);
  assign m_axis_tdata  = r_dat0;
  assign m_axis_tlast  = r_last0 & m_axis_tvalid;
  assign w_out_fire    = m_axis_tvalid & m_axis_tready;
  assign w_rem         = r_cnt - {1'b0, w_out_fire};
  // Flush if the link drops with an input packet in flight or beats still owed to the output.
  assign w_flush       = ~channel_up & ((r_state == PASS) | (w_rem != 2'd0));
  assign w_pkt_inc     = w_out_fire & r_last0;
  assign s_axis_tready = w_tready & ~aurora_rst;

  always_ff @(posedge aurora_clk) begin
    if (aurora_rst) begin
      r_state      <= IDLE;
      r_drop_trunc <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_drop_trunc <= w_drop_trunc_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_drop_trunc_nxt = r_drop_trunc;
    w_tready         = 1'b0;
    w_fwd            = 1'b0;
    w_drop_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!channel_up) begin
          w_tready = 1'b1;
          if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
              w_drop_inc = 1'b1;
            end else begin
              w_state_nxt      = DROP;
              w_drop_trunc_nxt = 1'b0;
            end
          end
        end else if (!tx_pause) begin
          w_tready = ~w_full;
          if (s_axis_tvalid && !w_full) begin
            w_fwd = 1'b1;
            if (!s_axis_tlast) w_state_nxt = PASS;
          end
        end
      end
      PASS: begin
        if (!channel_up) begin
          // Remainder of a truncated packet is swallowed without counting it as a drop.
          w_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt      = DROP;
            w_drop_trunc_nxt = 1'b1;
          end
        end else begin
          w_tready = ~w_full;
          if (s_axis_tvalid && !w_full) begin
            w_fwd = 1'b1;
            if (s_axis_tlast) w_state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        w_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          w_state_nxt = IDLE;
          w_drop_inc  = ~r_drop_trunc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aurora_clk) begin
    if (aurora_rst) begin
      r_dat0  <= '0;
      r_dat1  <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_cnt   <= 2'd0;
    end else if (w_flush) begin
      r_cnt <= 2'd0;
    end else begin
      if (w_out_fire) begin
        r_dat0  <= r_dat1;
        r_last0 <= r_last1;
      end
      if (w_fwd) begin
        if (w_rem == 2'd0) begin
          r_dat0  <= s_axis_tdata;
          r_last0 <= s_axis_tlast;
        end else begin
          r_dat1  <= s_axis_tdata;
          r_last1 <= s_axis_tlast;
        end
      end
      r_cnt <= w_rem + {1'b0, w_fwd};
    end
  end

`ifdef AURORA_TX_LINK_GATE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_pkt_cnt, r_drop_cnt, r_trunc_cnt;

  always_ff @(posedge aurora_clk) begin
    if (aurora_rst || clear_stats) begin
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
      r_trunc_cnt <= '0;
    end else begin
      if (w_pkt_inc && (r_pkt_cnt != '1))    r_pkt_cnt   <= r_pkt_cnt + CNT_ONE;
      if (w_drop_inc && (r_drop_cnt != '1))  r_drop_cnt  <= r_drop_cnt + CNT_ONE;
      if (w_flush && (r_trunc_cnt != '1))    r_trunc_cnt <= r_trunc_cnt + CNT_ONE;
    end
  end

  assign pkt_count   = r_pkt_cnt;
  assign drop_count  = r_drop_cnt;
  assign trunc_count = r_trunc_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = clear_stats ^ w_pkt_inc ^ w_drop_inc;
  assign pkt_count      = '0;
  assign drop_count     = '0;
  assign trunc_count    = '0;
`endif

endmodule

// File: tb/tb_aurora_tx_link_gate.sv
// Randomized and directed bench for aurora_tx_link_gate against a queue-based packet model.
module tb_aurora_tx_link_gate;
  localparam int W       = 64;
  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef AURORA_TX_LINK_GATE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aurora_rst, channel_up, tx_pause, clear_stats;
  logic [W-1:0]  s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [CW-1:0] pkt_count, drop_count, trunc_count;

  always #5 clk = ~clk;

  aurora_tx_link_gate #(.AXIS_AURORA_W(W), .CNT_W(CW)) dut (
    .aurora_clk(clk), .aurora_rst(aurora_rst), .channel_up(channel_up), .tx_pause(tx_pause),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .clear_stats(clear_stats),
    .pkt_count(pkt_count), .drop_count(drop_count), .trunc_count(trunc_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: pending output beats, and where the input stream sits within a packet.
  typedef struct packed { logic last; logic [W-1:0] dat; } beat_t;
  beat_t q[$];
  bit    m_mid, m_disc, m_trunc_pkt;
  int    e_pkt, e_drop, e_trunc;
  int    out_beats;
  bit    last_in_fire;

  logic [W-1:0] src_dat[$];
  bit           src_last[$];

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  function automatic int exp_cnt(input int v);
    return STATS_ON ? v : 0;
  endfunction

  function automatic bit model_rdy();
    if (aurora_rst) return 1'b0;
    if (!m_mid) begin
      if (!channel_up) return 1'b1;
      if (tx_pause) return 1'b0;
      return q.size() < 2;
    end
    if (m_disc || !channel_up) return 1'b1;
    return q.size() < 2;
  endfunction

  task automatic model_step(input bit rdy);
    bit ofire, ifire, flush;
    int pending;
    if (aurora_rst) begin
      q.delete();
      m_mid = 0; m_disc = 0; m_trunc_pkt = 0;
      e_pkt = 0; e_drop = 0; e_trunc = 0;
      last_in_fire = 0;
      return;
    end
    ofire   = (q.size() > 0) && m_axis_tready;
    ifire   = s_axis_tvalid && rdy;
    pending = q.size() - int'(ofire);
    flush   = !channel_up && ((m_mid && !m_disc) || pending > 0);
    if (ofire) begin
      out_beats++;
      if (q[0].last) e_pkt = sat(e_pkt + 1);
      void'(q.pop_front());
    end
    if (flush) begin
      q.delete();
      e_trunc = sat(e_trunc + 1);
    end
    if (m_mid && !m_disc && !channel_up) begin
      m_disc = 1; m_trunc_pkt = 1;
    end
    if (ifire) begin
      if (!m_mid && !channel_up) begin
        m_disc = 1; m_trunc_pkt = 0;
      end else if (!m_disc) begin
        q.push_back({s_axis_tlast, s_axis_tdata});
      end
      if (s_axis_tlast) begin
        if (m_disc && !m_trunc_pkt) e_drop = sat(e_drop + 1);
        m_mid = 0; m_disc = 0; m_trunc_pkt = 0;
      end else begin
        m_mid = 1;
      end
    end
    if (clear_stats) begin
      e_pkt = 0; e_drop = 0; e_trunc = 0;
    end
    last_in_fire = ifire;
  endtask

  task automatic cycle();
    bit rdy;
    @(negedge clk);
    rdy = model_rdy();
    chk("s_tready", 64'(s_axis_tready), 64'(rdy));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      chk("m_tdata", 64'(m_axis_tdata), 64'(q[0].dat));
      chk("m_tlast", 64'(m_axis_tlast), 64'(q[0].last));
    end
    chk("pkt_count", 64'(pkt_count), 64'(exp_cnt(e_pkt)));
    chk("drop_count", 64'(drop_count), 64'(exp_cnt(e_drop)));
    chk("trunc_count", 64'(trunc_count), 64'(exp_cnt(e_trunc)));
    model_step(rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic gen_pkts(input int n_pkts, input int len_lo, input int len_hi);
    for (int p = 0; p < n_pkts; p++) begin
      int len;
      len = (len_lo == len_hi) ? len_lo : int'($urandom_range(len_hi, len_lo));
      for (int b = 0; b < len; b++) begin
        src_dat.push_back({$urandom, $urandom});
        src_last.push_back(b == len - 1);
      end
    end
  endtask

  // mode 0: clean link, 1: link down, 2: pause mid-packet, 3: link loss on beat 3,
  // 4: toggling output ready with clear on tlast, 5: fully random
  task automatic run_stream(input int mode, input int max_cycles);
    int tcyc = 0;
    int src_idx = 0;
    s_axis_tvalid = 1'b0;
    while (src_dat.size() > 0 && tcyc < max_cycles) begin
      s_axis_tdata  = src_dat[0];
      s_axis_tlast  = src_last[0];
      clear_stats   = 1'b0;
      aurora_rst    = 1'b0;
      m_axis_tready = 1'b1;
      case (mode)
        0: begin channel_up = 1'b1; tx_pause = 1'b0; s_axis_tvalid = 1'b1; end
        1: begin channel_up = 1'b0; tx_pause = 1'b0; s_axis_tvalid = 1'b1; end
        2: begin channel_up = 1'b1; tx_pause = (src_idx >= 1) && (tcyc < 20); s_axis_tvalid = 1'b1; end
        3: begin channel_up = !(src_idx == 2 || src_idx == 3); tx_pause = 1'b0; s_axis_tvalid = 1'b1; end
        4: begin
          channel_up = 1'b1; tx_pause = 1'b0; s_axis_tvalid = 1'b1;
          m_axis_tready = tcyc[0];
          clear_stats = (q.size() > 0) && q[0].last && m_axis_tready;
        end
        default: begin
          if (!(s_axis_tvalid && !last_in_fire)) s_axis_tvalid = ($urandom_range(3, 0) != 0);
          if ($urandom_range(24, 0) == 0) channel_up = ~channel_up;
          if ($urandom_range(4, 0) == 0) tx_pause = ~tx_pause;
          m_axis_tready = ($urandom_range(3, 0) != 0);
          clear_stats   = ($urandom_range(149, 0) == 0);
          aurora_rst    = (tcyc == 200);
        end
      endcase
      cycle();
      if (last_in_fire) begin
        void'(src_dat.pop_front());
        void'(src_last.pop_front());
        src_idx++;
      end
      tcyc++;
    end
    if (src_dat.size() > 0) chk("stream_timeout", 64'(src_dat.size()), 64'd0);
    src_dat.delete();
    src_last.delete();
    s_axis_tvalid = 1'b0;
    clear_stats   = 1'b0;
    aurora_rst    = 1'b0;
    m_axis_tready = 1'b1;
    tx_pause      = 1'b0;
    repeat (6) cycle();
  endtask

  task automatic start_test();
    s_axis_tvalid = 1'b0;
    channel_up    = 1'b1;
    tx_pause      = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) cycle();
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    out_beats   = 0;
  endtask

  initial begin
    aurora_rst = 1'b1; channel_up = 1'b1; tx_pause = 1'b0; clear_stats = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_trunc", 64'(trunc_count), 64'd0);
    aurora_rst = 1'b0;
    s_axis_tvalid = 1'b0;

    start_test();
    gen_pkts(3, 4, 4);
    run_stream(0, 100);
    chk("t1_beats", 64'(out_beats), 64'd12);
    chk("t1_pkt", 64'(pkt_count), 64'(exp_cnt(3)));

    start_test();
    gen_pkts(2, 5, 5);
    run_stream(1, 100);
    chk("t2_beats", 64'(out_beats), 64'd0);
    chk("t2_drop", 64'(drop_count), 64'(exp_cnt(2)));
    chk("t2_pkt", 64'(pkt_count), 64'd0);

    start_test();
    gen_pkts(1, 6, 6);
    gen_pkts(1, 2, 2);
    run_stream(2, 100);
    chk("t3_beats", 64'(out_beats), 64'd8);
    chk("t3_pkt", 64'(pkt_count), 64'(exp_cnt(2)));

    start_test();
    gen_pkts(1, 8, 8);
    gen_pkts(1, 2, 2);
    run_stream(3, 100);
    chk("t4_beats", 64'(out_beats), 64'd4);
    chk("t4_trunc", 64'(trunc_count), 64'(exp_cnt(1)));
    chk("t4_drop", 64'(drop_count), 64'd0);
    chk("t4_pkt", 64'(pkt_count), 64'(exp_cnt(1)));

    start_test();
    gen_pkts(1, 16, 16);
    run_stream(4, 200);
    chk("t5_beats", 64'(out_beats), 64'd16);
    chk("t5_pkt_cleared", 64'(pkt_count), 64'd0);

    start_test();
    gen_pkts(150, 1, 6);
    run_stream(5, 4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
